// File: rtl/stripe_pkg.sv
// stripe_pkg: shared state type and lane-mask helper for the lane striper gearbox.
package stripe_pkg;

   localparam int MAX_LANES = 8;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } state_t;

   // Mask with the low n bits set, never wider than the configured lane count.
   function automatic logic [MAX_LANES-1:0] lane_mask(input int unsigned n, input int unsigned lanes);
      logic [MAX_LANES-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MAX_LANES; i++) begin
         m[i] = (i < n) && (i < lanes);
      end
      return m;
   endfunction

endpackage

// File: rtl/stripe_gearbox_if.sv
// stripe_gearbox_if: word input handshake, flush and the parallel lane output bus.
interface stripe_gearbox_if #(
   parameter int WIDTH = 32,
   parameter int LANES = 2
);
   logic [WIDTH-1:0]       data_in;
   logic                   valid_in;
   logic                   ready_in;
   logic                   flush;
   logic [LANES*WIDTH-1:0] lane_data;
   logic [LANES-1:0]       lane_valid;
   logic                   ready_out;
   logic [15:0]            group_count;

   modport master (
      output data_in, valid_in, flush, ready_out,
      input  ready_in, lane_data, lane_valid, group_count
   );

   modport slave (
      input  data_in, valid_in, flush, ready_out,
      output ready_in, lane_data, lane_valid, group_count
   );
endinterface

// File: rtl/stripe_out_reg.sv
// stripe_out_reg: presented-group register, slot-free logic and accepted-group counter.
module stripe_out_reg #(
   parameter int WIDTH = 32,
   parameter int LANES = 2
) (
   input  logic                   clk_2f,
   input  logic                   reset,
   input  logic                   load,
   input  logic [LANES*WIDTH-1:0] load_data,
   input  logic [LANES-1:0]       load_mask,
   input  logic                   ready_out,
   output logic                   slot_free,
   output logic [LANES*WIDTH-1:0] lane_data,
   output logic [LANES-1:0]       lane_valid,
   output logic [15:0]            group_count
);

   logic drain;

   assign drain     = (|lane_valid) && ready_out;
   assign slot_free = ~(|lane_valid) || ready_out;

   // A new group replaces the presented one; a drain alone only drops the valids, data is kept.
   // NOTE: non-blocking (<=) for all registered state so every flop samples pre-edge values.
   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         lane_data  <= '0;
         lane_valid <= '0;
      end else if (load) begin
         lane_data  <= load_data;
         lane_valid <= load_mask;
      end else if (drain) begin
         lane_valid <= '0;
      end
   end

   // Count groups taken downstream; wraps at 2^16 by width.
   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         group_count <= '0;
      end else if (drain) begin
         group_count <= group_count + 16'd1;
      end
   end

endmodule

// File: rtl/stripe_gearbox.sv
// stripe_gearbox: collects LANES words into a group and hands it to the lane output register.
module stripe_gearbox
   import stripe_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LANES = 2,
   parameter int IDXW  = $clog2(LANES)
) (
   input  logic             clk_2f,
   input  logic             reset,
   stripe_gearbox_if.slave  bus
);

   state_t                 state, state_next;
   logic [IDXW-1:0]        idx;
   logic [WIDTH-1:0]       collect [LANES];
   logic [LANES-1:0]       held_mask;

   logic                   accept;
   logic                   complete;
   logic                   slot_free;
   logic                   load;
   logic [IDXW:0]          n;
   logic [LANES-1:0]       grp_mask;
   logic [LANES-1:0]       load_mask;
   logic [LANES*WIDTH-1:0] load_data;

   logic [LANES*WIDTH-1:0] out_data;
   logic [LANES-1:0]       out_valid;
   logic [15:0]            out_count;

   // ready_in depends on registered state only.
   assign bus.ready_in = (state == ST_FILL);
   assign accept       = (state == ST_FILL) && bus.valid_in;
   assign load         = (complete || (state == ST_FULL)) && slot_free;

   // Group formation: words held so far plus the one arriving this cycle, unfilled lanes zeroed.
   // NOTE: every signal written here gets a default first so no latch can be inferred.
   always_comb begin
      n         = {1'b0, idx} + {{IDXW{1'b0}}, accept};
      grp_mask  = LANES'(lane_mask(32'(n), LANES));
      complete  = 1'b0;
      if (state == ST_FILL) begin
         complete = (accept && (idx == IDXW'(LANES-1))) || (bus.flush && (n != '0));
      end
      load_mask = (state == ST_FULL) ? held_mask : grp_mask;
      load_data = '0;
      for (int k = 0; k < LANES; k++) begin
         if (load_mask[k]) begin
            load_data[k*WIDTH +: WIDTH] = (accept && (idx == IDXW'(k))) ? bus.data_in : collect[k];
         end
      end
   end

   // Next state: park in FULL when a group completes but the output slot is occupied.
   always_comb begin
      state_next = state;
      case (state)
         ST_FILL: if (complete && !slot_free) state_next = ST_FULL;
         ST_FULL: if (slot_free)              state_next = ST_FILL;
         default:                             state_next = ST_FILL;
      endcase
   end

   // State register.
   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) state <= ST_FILL;
      else        state <= state_next;
   end

   // Collect buffer, fill index and the mask of a group waiting in FULL.
   // NOTE: the buffer is cleared on reset too, so reset leaves no trace of a discarded group.
   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         idx       <= '0;
         held_mask <= '0;
         for (int k = 0; k < LANES; k++) collect[k] <= '0;
      end else begin
         if (accept) collect[idx] <= bus.data_in;
         if (complete) begin
            idx <= '0;
            if (!slot_free) held_mask <= grp_mask;
         end else if (accept) begin
            idx <= idx + 1'b1;
         end
      end
   end

   stripe_out_reg #(
      .WIDTH (WIDTH),
      .LANES (LANES)
   ) u_out_reg (
      .clk_2f      (clk_2f),
      .reset       (reset),
      .load        (load),
      .load_data   (load_data),
      .load_mask   (load_mask),
      .ready_out   (bus.ready_out),
      .slot_free   (slot_free),
      .lane_data   (out_data),
      .lane_valid  (out_valid),
      .group_count (out_count)
   );

   assign bus.lane_data   = out_data;
   assign bus.lane_valid  = out_valid;
   assign bus.group_count = out_count;

endmodule

// File: tb/tb_stripe_gearbox.sv
// tb_stripe_gearbox: three gearboxes (2, 4, 8 lanes) driven in lockstep and checked against a queue-level model.
module tb_stripe_gearbox;

   localparam int W  = 32;
   localparam int NI = 3;

   logic         clk_2f = 1'b0;
   logic         reset  = 1'b0;
   logic [W-1:0] data_in;
   logic         valid_in;
   logic         flush;
   logic         ready_out;

   int n_checks;
   int n_errors;

   always #5 clk_2f = ~clk_2f;

   stripe_gearbox_if #(.WIDTH(W), .LANES(2)) bus2 ();
   stripe_gearbox_if #(.WIDTH(W), .LANES(4)) bus4 ();
   stripe_gearbox_if #(.WIDTH(W), .LANES(8)) bus8 ();

   assign bus2.data_in = data_in;  assign bus2.valid_in = valid_in;
   assign bus2.flush   = flush;    assign bus2.ready_out = ready_out;
   assign bus4.data_in = data_in;  assign bus4.valid_in = valid_in;
   assign bus4.flush   = flush;    assign bus4.ready_out = ready_out;
   assign bus8.data_in = data_in;  assign bus8.valid_in = valid_in;
   assign bus8.flush   = flush;    assign bus8.ready_out = ready_out;

   stripe_gearbox #(.WIDTH(W), .LANES(2)) dut2 (.clk_2f(clk_2f), .reset(reset), .bus(bus2));
   stripe_gearbox #(.WIDTH(W), .LANES(4)) dut4 (.clk_2f(clk_2f), .reset(reset), .bus(bus4));
   stripe_gearbox #(.WIDTH(W), .LANES(8)) dut8 (.clk_2f(clk_2f), .reset(reset), .bus(bus8));

   // Outputs widened to 8 lanes so one model serves all instances.
   logic [8*W-1:0] o_data  [NI];
   logic [7:0]     o_valid [NI];
   logic [15:0]    o_cnt   [NI];
   logic           o_ready [NI];

   assign o_data[0]  = {{(6*W){1'b0}}, bus2.lane_data};
   assign o_data[1]  = {{(4*W){1'b0}}, bus4.lane_data};
   assign o_data[2]  = bus8.lane_data;
   assign o_valid[0] = {6'b0, bus2.lane_valid};
   assign o_valid[1] = {4'b0, bus4.lane_valid};
   assign o_valid[2] = bus8.lane_valid;
   assign o_cnt[0]   = bus2.group_count;
   assign o_cnt[1]   = bus4.group_count;
   assign o_cnt[2]   = bus8.group_count;
   assign o_ready[0] = bus2.ready_in;
   assign o_ready[1] = bus4.ready_in;
   assign o_ready[2] = bus8.ready_in;

   // ---------------- reference model ----------------
   logic [W-1:0]   m_buf   [NI][8];
   int             m_n     [NI];
   bit             m_full  [NI];
   logic [8*W-1:0] m_pdata [NI];
   logic [7:0]     m_pmask [NI];
   logic [8*W-1:0] m_odata [NI];
   logic [7:0]     m_omask [NI];
   int unsigned    m_cnt   [NI];

   function automatic int lanes_of(input int i);
      return 2 << i;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         m_n[i] = 0; m_full[i] = 0; m_pdata[i] = '0; m_pmask[i] = '0;
         m_odata[i] = '0; m_omask[i] = '0; m_cnt[i] = 0;
      end
   endtask

   task automatic model_step(input int i, input logic v, input logic [W-1:0] d, input logic f, input logic r);
      logic [8*W-1:0] gd;
      logic [7:0]     gm;
      bit             free, drained, formed;
      free    = (m_omask[i] == 0) || r;
      drained = (m_omask[i] != 0) && r;
      formed  = 0;
      if (drained) m_cnt[i]++;
      if (m_full[i]) begin
         if (free) begin
            m_odata[i] = m_pdata[i]; m_omask[i] = m_pmask[i]; m_full[i] = 0;
         end
      end else begin
         if (v) begin
            m_buf[i][m_n[i]] = d;
            m_n[i]++;
         end
         if (m_n[i] == lanes_of(i) || (f && m_n[i] > 0)) begin
            gd = '0; gm = '0;
            for (int k = 0; k < m_n[i]; k++) begin
               gd[k*W +: W] = m_buf[i][k];
               gm[k] = 1'b1;
            end
            m_n[i] = 0;
            formed = 1;
            if (free) begin
               m_odata[i] = gd; m_omask[i] = gm;
            end else begin
               m_pdata[i] = gd; m_pmask[i] = gm; m_full[i] = 1;
            end
         end
         if (!formed && drained) m_omask[i] = '0;
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < NI; i++) begin
         check($sformatf("L%0d ready_in", lanes_of(i)), o_ready[i], !m_full[i]);
         check($sformatf("L%0d lane_valid", lanes_of(i)), o_valid[i], m_omask[i]);
         check($sformatf("L%0d lane_data", lanes_of(i)), o_data[i], m_odata[i]);
         check($sformatf("L%0d group_count", lanes_of(i)), o_cnt[i], 16'(m_cnt[i]));
      end
   endtask

   task automatic cycle(input logic v, input logic [W-1:0] d, input logic f, input logic r, input bit chk);
      valid_in = v; data_in = d; flush = f; ready_out = r;
      for (int i = 0; i < NI; i++) model_step(i, v, d, f, r);
      @(posedge clk_2f);
      #1;
      if (chk) check_all();
   endtask

   // Reset asserted mid-cycle; outputs must clear before any clock edge.
   task automatic do_reset();
      valid_in = 1'b0; flush = 1'b0; ready_out = 1'b0; data_in = '0;
      reset = 1'b0;
      #2;
      model_reset();
      check_all();
      check("reset L8 ready_in", o_ready[2], 1'b1);
      check("reset L4 lane_valid", o_valid[1], 8'h00);
      @(posedge clk_2f);
      #3;
      reset = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic         v;
      logic [W-1:0] d;
      logic         f;
      logic         r;
      logic         e_ready;
      logic [3:0]   e_valid;
      logic [127:0] e_data;
      logic [15:0]  e_cnt;
   } vec_t;

   vec_t vecs [12];

   function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic f, input logic r,
                               input logic er, input logic [3:0] ev, input logic [127:0] ed, input logic [15:0] ec);
      vec_t t;
      t.v = v; t.d = d; t.f = f; t.r = r;
      t.e_ready = er; t.e_valid = ev; t.e_data = ed; t.e_cnt = ec;
      return t;
   endfunction

   initial begin
      logic [127:0] g0, g1;
      n_checks = 0;
      n_errors = 0;
      valid_in = 1'b0; flush = 1'b0; ready_out = 1'b0; data_in = '0;

      // LANES=4 backpressure: 10 words offered with ready_out low, then drain.
      g0 = {32'h103, 32'h102, 32'h101, 32'h100};
      g1 = {32'h107, 32'h106, 32'h105, 32'h104};
      vecs[0]  = mk(1, 32'h100, 0, 0, 1, 4'h0, '0, 16'd0);
      vecs[1]  = mk(1, 32'h101, 0, 0, 1, 4'h0, '0, 16'd0);
      vecs[2]  = mk(1, 32'h102, 0, 0, 1, 4'h0, '0, 16'd0);
      vecs[3]  = mk(1, 32'h103, 0, 0, 1, 4'hF, g0, 16'd0);
      vecs[4]  = mk(1, 32'h104, 0, 0, 1, 4'hF, g0, 16'd0);
      vecs[5]  = mk(1, 32'h105, 0, 0, 1, 4'hF, g0, 16'd0);
      vecs[6]  = mk(1, 32'h106, 0, 0, 1, 4'hF, g0, 16'd0);
      vecs[7]  = mk(1, 32'h107, 0, 0, 0, 4'hF, g0, 16'd0);
      vecs[8]  = mk(1, 32'h108, 0, 0, 0, 4'hF, g0, 16'd0);
      vecs[9]  = mk(1, 32'h109, 0, 0, 0, 4'hF, g0, 16'd0);
      vecs[10] = mk(0, 32'h0,   0, 1, 1, 4'hF, g1, 16'd1);
      vecs[11] = mk(0, 32'h0,   0, 1, 1, 4'h0, g1, 16'd2);

      do_reset();
      check("post-reset L2 ready_in", o_ready[0], 1'b1);
      check("post-reset L2 group_count", o_cnt[0], 16'd0);

      // LANES=2 back-to-back words with ready_out high.
      cycle(1, 32'hFFFFFFFF, 0, 1, 1);
      check("L2 first word no output", o_valid[0], 8'h00);
      cycle(1, 32'hFFFFFFFE, 0, 1, 1);
      check("L2 grp0 data", o_data[0][63:0], 64'hFFFFFFFE_FFFFFFFF);
      check("L2 grp0 valid", o_valid[0], 8'h03);
      cycle(1, 32'hFFFFFFFD, 0, 1, 1);
      check("L2 ready_in no bubble", o_ready[0], 1'b1);
      cycle(1, 32'hFFFFFFFC, 0, 1, 1);
      check("L2 grp1 data", o_data[0][63:0], 64'hFFFFFFFC_FFFFFFFD);
      check("L2 grp1 valid", o_valid[0], 8'h03);
      cycle(0, 32'h0, 0, 1, 1);
      check("L2 group_count", o_cnt[0], 16'd2);

      // Table-driven LANES=4 backpressure sequence.
      do_reset();
      for (int t = 0; t < 12; t++) begin
         cycle(vecs[t].v, vecs[t].d, vecs[t].f, vecs[t].r, 1);
         check($sformatf("vec%0d L4 ready_in", t), o_ready[1], vecs[t].e_ready);
         check($sformatf("vec%0d L4 lane_valid", t), o_valid[1], {4'b0, vecs[t].e_valid});
         check($sformatf("vec%0d L4 lane_data", t), o_data[1][127:0], vecs[t].e_data);
         check($sformatf("vec%0d L4 group_count", t), o_cnt[1], vecs[t].e_cnt);
      end

      // LANES=4 partial flush after three words, then the next word lands in lane 0.
      do_reset();
      cycle(1, 32'hA, 0, 1, 1);
      cycle(1, 32'hB, 0, 1, 1);
      cycle(1, 32'hC, 0, 1, 1);
      cycle(0, 32'h0, 1, 1, 1);
      check("L4 flush valid", o_valid[1], 8'h07);
      check("L4 flush lane3 zero", o_data[1][127:96], 32'h0);
      check("L4 flush data", o_data[1][127:0], {32'h0, 32'hC, 32'hB, 32'hA});
      cycle(1, 32'hD, 0, 1, 1);
      cycle(1, 32'hE, 0, 1, 1);
      cycle(1, 32'hF, 0, 1, 1);
      cycle(1, 32'h10, 0, 1, 1);
      check("L4 post-flush lane0", o_data[1][31:0], 32'hD);
      check("L4 post-flush valid", o_valid[1], 8'h0F);
      check("L4 post-flush count", o_cnt[1], 16'd1);

      // LANES=4 flush coinciding with the 4th word: one full group only.
      do_reset();
      cycle(1, 32'h1, 0, 1, 1);
      cycle(1, 32'h2, 0, 1, 1);
      cycle(1, 32'h3, 0, 1, 1);
      cycle(1, 32'h4, 1, 1, 1);
      check("L4 flush+last valid", o_valid[1], 8'h0F);
      check("L4 flush+last data", o_data[1][127:0], {32'h4, 32'h3, 32'h2, 32'h1});
      cycle(0, 32'h0, 0, 1, 1);
      cycle(0, 32'h0, 1, 1, 1);
      check("L4 single group count", o_cnt[1], 16'd1);
      check("L4 idle flush no-op", o_valid[1], 8'h00);

      // LANES=8 reset mid-group (L2 instance sits in FULL at this point).
      do_reset();
      for (int k = 0; k < 5; k++) cycle(1, 32'h50 + 32'(k), 0, 0, 1);
      check("L2 full before reset", o_ready[0], 1'b0);
      do_reset();
      check("L8 cleared valid", o_valid[2], 8'h00);
      check("L2 ready after reset", o_ready[0], 1'b1);
      for (int k = 0; k < 8; k++) cycle(1, 32'h80 + 32'(k), 0, 1, 1);
      check("L8 clean group valid", o_valid[2], 8'hFF);
      check("L8 clean group data", o_data[2],
            {32'h87, 32'h86, 32'h85, 32'h84, 32'h83, 32'h82, 32'h81, 32'h80});

      // Randomized traffic against the model.
      do_reset();
      for (int t = 0; t < 3000; t++) begin
         cycle($urandom_range(0, 99) < 75, $urandom, $urandom_range(0, 99) < 8,
               $urandom_range(0, 99) < 55, 1);
      end

      // group_count wrap: one-word flushed groups every cycle, 65537 groups drained.
      do_reset();
      for (int t = 0; t < 65537; t++) cycle(1, $urandom, 1, 1, 0);
      cycle(0, 32'h0, 0, 1, 1);
      check("L2 group_count wrap", o_cnt[0], 16'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/stripe_gearbox.md
# stripe_gearbox

Parametrised N-lane striper gearbox. It accepts one WIDTH-bit word per clk_2f cycle under a valid/ready handshake and collects LANES consecutive words into a group. Each completed group is presented on all lanes in parallel, with per-lane valids and output backpressure. A flush input emits a partial group with a lane mask. It replaces the fixed 2-lane, 32-bit striper in the striping path, upstream of the per-lane logic and the unstriper.

## Interface
- WIDTH, 32: bits per word and per lane.
- LANES, 2: lane count; legal values 2, 4, 8.
- IDXW, $clog2(LANES): lane index width (derived, do not override).
- clk_2f  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- data_in  in  WIDTH  input word.
- valid_in  in  1  data_in valid.
- ready_in  out  1  block can accept a word; a word transfers when valid_in && ready_in at an edge.
- flush  in  1  emit the current partial group.
- lane_data  out  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- lane_valid  out  LANES  per-lane valid mask of the presented group.
- ready_out  in  1  downstream accepts the presented group.
- group_count  out  16  completed and flushed groups accepted downstream; wraps at 2^16.

## Operation
- Word order: the k-th accepted word after reset or after a group boundary goes to lane k (lane 0 first).
- Storage: one collect buffer (LANES words plus idx counter) and one output register (lane_data/lane_valid).
- Output slot is free when lane_valid == 0, or when it is draining (|lane_valid && ready_out) in the same cycle.
- States:
  - FILL: ready_in = 1. Each accepted word is written to collect[idx] and idx increments.
    - If the accepted word completes the group (idx == LANES-1) and the slot is free: load the group straight into the output register with lane_valid = all ones, set idx = 0, stay in FILL.
    - If the slot is not free: latch the word, go to FULL.
  - FULL: ready_in = 0. When the slot is free: transfer the group with lane_valid = all ones, set idx = 0, return to FILL.
- Flush, taking effect in FILL only; ignored in FULL:
  - Let n = idx, plus 1 if a word is accepted in the same cycle.
  - n == 0: no-op.
  - n == LANES: normal completion.
  - Otherwise the partial group is treated as complete: lane_valid = low n bits set, unfilled lanes' data = 0, idx = 0.
  - If the slot is not free, go to FULL with the partial mask held.
- group_count increments on every edge with |lane_valid && ready_out.
- lane_data holds its value while ready_out = 0. On drain with no new group, lane_valid goes to 0 and lane_data is unchanged.

## Timing
- Reset values: lane_data = 0, lane_valid = 0, group_count = 0, idx = 0, state = FILL, so ready_in = 1 while reset is low and afterwards.
- ready_in is a function of registered state only. There is no combinational path from valid_in, ready_out or flush to ready_in.
- Latency: a group is visible on lane_data/lane_valid one edge after its last word (or flush) is accepted, when the slot is free.
- Throughput: one word per cycle sustained with ready_out held high; no bubble at group boundaries.
- Backpressure: with ready_out = 0, the block accepts at most one additional full group (2*LANES words total) before ready_in falls.
- Simultaneous drain and completion at the same edge: the new group replaces the old one; lane_valid stays high and group_count increments.
- Reset asserted mid-group or in FULL discards all data. No partial group is emitted.

## Structure
- Package stripe_pkg holds:
  - state localparams ST_FILL, ST_FULL;
  - function lane_mask(n, LANES) returning the low-n-bits mask.
- Sub-module stripe_out_reg implements the output register, the slot-free logic and group_count. stripe_gearbox holds the collect buffer, idx and the state machine.

## Test plan
- LANES=2, reset low then released, ready_out = 1, words 0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFFFD, 0xFFFFFFFC back to back:
  - edge after word 2: lane0 = 0xFFFFFFFF, lane1 = 0xFFFFFFFE, lane_valid = 2'b11;
  - next group follows two cycles later with no bubble;
  - group_count = 2.
- LANES=4, ready_out = 0, 10 words offered:
  - exactly 8 accepted, ready_in = 0 from the edge the 8th is accepted;
  - raise ready_out: groups {0..3} then {4..7} drain on consecutive edges, ready_in returns.
- LANES=4, 3 words 0xA, 0xB, 0xC then flush, ready_out = 1:
  - lane_valid = 4'b0111, lane3 = 0;
  - next word goes to lane 0.
- LANES=4, flush asserted together with the 4th word: full group, lane_valid = 4'b1111, one group only.
- LANES=8, reset pulsed low after 5 words:
  - outputs clear immediately, ready_in = 1;
  - next 8 words form a clean group starting at lane 0.
- LANES=2, ready_out held high for 65537 groups: group_count wraps to 1.
